fifo_read_adapter: RTL
======================

FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of FIFO read data and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the drained-word counter.
REQ-003 SHALL have port read_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port read_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port p_read_empty, input, 1: FIFO read-domain empty flag.
REQ-006 SHALL have port p_read_data, input, DATA_WIDTH: FIFO read data, valid one cycle after an accepted read.
REQ-007 SHALL have port p_read_en, output, 1: FIFO read request.
REQ-008 SHALL have port p_out_valid, output, 1: stream word available.
REQ-009 SHALL have port p_out_ready, input, 1: downstream accepts the word.
REQ-010 SHALL have port p_out_data, output, DATA_WIDTH: stream word.
REQ-011 SHALL have port p_word_count, output, CNT_WIDTH: count of words delivered downstream.

Function
REQ-012 SHALL hold a 3-entry output buffer with occupancy occ (0..3) and an in-flight flag inflight (0/1).
REQ-013 SHALL define an accepted read as p_read_en && !p_read_empty, and an accepted pop as p_out_valid && p_out_ready.
REQ-014 SHALL drive p_read_en = !p_read_empty && (occ + inflight < 3); it SHALL NOT depend combinationally on p_out_ready.
REQ-015 SHALL set inflight to 1 in the cycle after an accepted read, else 0.
REQ-016 SHALL write p_read_data into the buffer tail on every cycle where inflight is 1; the write SHALL never be dropped.
REQ-017 SHALL drive p_out_valid = (occ != 0) and p_out_data = buffer head.
REQ-018 SHALL update occ: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-019 SHALL advance the 2-bit head and tail pointers modulo 3 (2 wraps to 0).
REQ-020 SHALL keep p_out_data stable while p_out_valid && !p_out_ready.
REQ-021 SHALL sustain one word per cycle when the FIFO is non-empty and p_out_ready is held high, after an initial 2-cycle latency from p_read_empty falling to p_out_valid rising.
REQ-022 SHALL never overflow the buffer (occ + inflight <= 3 at all times) and never pop with occ == 0.
REQ-023 SHALL increment p_word_count by 1 per accepted pop, wrapping modulo 2^CNT_WIDTH.

Reset
REQ-024 SHALL, while read_rst is high, force p_read_en=0, p_out_valid=0, p_out_data=0, p_word_count=0, occ=0, inflight=0, pointers=0.
REQ-025 SHALL discard any in-flight or buffered word when reset asserts mid-operation; the first post-reset p_read_en SHALL occur no earlier than the first read_clk edge after deassertion.

Configuration
REQ-026 SHALL compile the drained-word counter only when FIFO_READ_ADAPTER_CNT_EN is defined.
REQ-027 SHALL, without FIFO_READ_ADAPTER_CNT_EN, keep port p_word_count and tie it to constant 0 with no counter flops.

Structure
REQ-028 SHALL place constant BUF_DEPTH=3 and the occupancy and pointer typedefs in package fifo_adapter_pkg.
REQ-029 SHALL implement the 3-entry storage with pointers as sub-module fifo_adapter_buf; control and counter remain in fifo_read_adapter.

Verification
REQ-030 Reset: assert read_rst mid-stream with occ=2, inflight=1 -> next cycle p_out_valid=0, p_read_en=0, p_word_count=0.
REQ-031 Streaming: FIFO preloaded with 0x01..0x10, p_out_ready=1 -> 16 words in order, one per cycle after 2-cycle latency, p_word_count=16.
REQ-032 Backpressure: p_out_ready=0 with FIFO holding 5 words -> exactly 3 accepted reads, occ=3, p_read_en=0, p_out_data=0x01 stable; releasing ready delivers 0x01..0x05 in order.
REQ-033 Empty boundary: p_read_empty=1 with p_read_en forced attempts -> no buffer write, occ unchanged, p_out_valid low once drained.
REQ-034 Wrap: 10 words with ready toggling 1,0,1,0 -> pointers wrap 2->0 three times, data order preserved, simultaneous write+pop leaves occ unchanged.
REQ-035 Config: build without FIFO_READ_ADAPTER_CNT_EN, run REQ-031 stimulus -> identical stream, p_word_count=0 throughout.

Source files
------------

// File: rtl/fifo_adapter_pkg.sv
// fifo_adapter_pkg: shared constants and types for the FIFO read adapter.
//   BUF_DEPTH : number of output buffer entries
//   occ_t     : buffer occupancy (0..BUF_DEPTH)
//   ptr_t     : head/tail pointer (0..BUF_DEPTH-1)
//   ptr_inc   : pointer increment modulo BUF_DEPTH
package fifo_adapter_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0] occ_t;
    typedef logic [1:0] ptr_t;

    // Depth is not a power of two, so the wrap is explicit.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_adapter_buf.sv
// fifo_adapter_buf: 3-entry circular storage with head/tail pointers.
// Occupancy is tracked by the caller; this block only stores and indexes.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset (clears storage and pointers)
//   wr_i        : write wr_data_i at tail, advance tail
//   wr_data_i   : data to write
//   pop_i       : advance head
//   head_data_o : entry at head
module fifo_adapter_buf
    import fifo_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;

    assign head_d      = pop_i ? ptr_inc(head_q) : head_q;
    assign tail_d      = wr_i  ? ptr_inc(tail_q) : tail_q;
    // Storage clears on reset so the head reads as zero afterwards.
    assign head_data_o = mem_q[head_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (wr_i) mem_q[tail_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter: turns a FIFO read port (read data one cycle after an
// accepted read) into a valid/ready stream with a 3-entry skid buffer, so
// p_read_en never depends combinationally on p_out_ready.
//   read_clk, read_rst : clock, asynchronous active-high reset
//   p_read_empty       : FIFO empty flag
//   p_read_data        : FIFO read data (valid one cycle after accepted read)
//   p_read_en          : FIFO read request
//   p_out_valid/ready/data : output stream
//   p_word_count       : words delivered downstream (wraps)
// Macro FIFO_READ_ADAPTER_CNT_EN: when defined, p_word_count is a live
// counter; otherwise it is tied to zero with no flops.
module fifo_read_adapter
    import fifo_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  read_clk,
    input  logic                  read_rst,
    input  logic                  p_read_empty,
    input  logic [DATA_WIDTH-1:0] p_read_data,
    output logic                  p_read_en,
    output logic                  p_out_valid,
    input  logic                  p_out_ready,
    output logic [DATA_WIDTH-1:0] p_out_data,
    output logic [CNT_WIDTH-1:0]  p_word_count
);

    occ_t       occ_q, occ_d;
    logic       inflight_q, inflight_d;
    // Holds off reads until the first clock edge after reset release.
    logic       run_q;
    logic [2:0] pending;
    logic       wr, pop;

    assign pending     = {1'b0, occ_q} + {2'b00, inflight_q};
    // Reserve a slot for every read in flight; the write can then never drop.
    assign p_read_en   = run_q && !p_read_empty && (pending < 3'(BUF_DEPTH));
    assign p_out_valid = (occ_q != '0);
    assign wr          = inflight_q;
    assign pop         = p_out_valid && p_out_ready;
    assign inflight_d  = p_read_en && !p_read_empty;

    always_comb begin
        occ_d = occ_q;
        case ({wr, pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            run_q      <= 1'b1;
        end
    end

    fifo_adapter_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i       (read_clk),
        .rst_i       (read_rst),
        .wr_i        (wr),
        .wr_data_i   (p_read_data),
        .pop_i       (pop),
        .head_data_o (p_out_data)
    );

`ifdef FIFO_READ_ADAPTER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_d        = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    assign p_word_count = cnt_q;

    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign p_word_count = '0;
`endif

endmodule
